// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The scoreboard entry carries a fixed-width register field so one type serves every REG_AW up to RD_W.
package pipe_ctrl_pkg;

    localparam int RD_W   = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic            v;
        logic [RD_W-1:0] rd;
        logic            wr;
        logic            ld;
    } sb_entry_t;

    // Stage S_k moves to S_k+1 by the time the consumer reaches EX.
    function automatic int unsigned fwd_code(input int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority matcher for one source operand against the comparable scoreboard stages.
// The youngest (lowest-numbered) matching stage wins.
module pipe_fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int FWD_W  = $clog2(DEPTH + 1)
) (
    input  logic                   valid,
    input  logic                   used,
    input  logic [REG_AW-1:0]      src,
    input  sb_entry_t [DEPTH-1:1]  sb,
    output logic                   hit,
    output logic [FWD_W-1:0]       k,
    output logic                   is_load
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the youngest match is the last one written.
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (valid && used && (src != '0) && sb[i].v && sb[i].wr &&
                (sb[i].rd == RD_W'(src))) begin
                hit     = 1'b1;
                k       = FWD_W'(i);
                is_load = sb[i].ld;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard controller: load-use stall, registered forward selects,
// multi-cycle redirect flush, external freeze and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 1,
    parameter int FWD_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              redirect,
    input  logic              ext_stall,
    output logic              pc_wr,
    output logic              ifid_wr,
    output logic              bubble,
    output logic              flush,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [31:0]       stall_cnt
);

    localparam int FC_W = 2;

    // The WB stage is never compared (write-before-read register file), so only S1..S_DEPTH-1 are held.
    sb_entry_t [DEPTH-1:1] sb_q;
    sb_entry_t             s1_next;
    logic [FC_W-1:0]       flush_cnt_q;
    logic                  redir_pend_q;

    logic                  redir_go, flushing, id_live, load_use;
    logic                  hit_a, hit_b, ld_a, ld_b;
    logic [FWD_W-1:0]      k_a, k_b;

    assign redir_go = ~ext_stall & (redirect | redir_pend_q);
    assign flushing = (flush_cnt_q != '0);
    assign id_live  = id_valid & ~flushing & ~redir_go;

    pipe_fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_a (
        .valid   (id_live),
        .used    (id_rs_used),
        .src     (id_rs),
        .sb      (sb_q),
        .hit     (hit_a),
        .k       (k_a),
        .is_load (ld_a)
    );

    pipe_fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FWD_W(FWD_W)) u_match_b (
        .valid   (id_live),
        .used    (id_rt_used),
        .src     (id_rt),
        .sb      (sb_q),
        .hit     (hit_b),
        .k       (k_b),
        .is_load (ld_b)
    );

    assign load_use = ~ext_stall &
                      ((hit_a & ld_a & (int'(k_a) <= LOAD_LAT)) |
                       (hit_b & ld_b & (int'(k_b) <= LOAD_LAT)));

    always_comb begin
        pc_wr   = 1'b1;
        ifid_wr = 1'b1;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (ext_stall) begin
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
            flush   = flushing;
        end else if (redir_go || flushing) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (load_use) begin
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
            bubble  = 1'b1;
        end
    end

    always_comb begin
        s1_next = '0;
        if (!bubble) begin
            s1_next.v  = id_valid;
            s1_next.rd = RD_W'(id_rd);
            s1_next.wr = id_wr;
            s1_next.ld = id_load;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the scoreboard is small flop storage and is reset so no stale entry can match after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q         <= '0;
            fwd_a        <= FWD_W'(FWD_RF);
            fwd_b        <= FWD_W'(FWD_RF);
            flush_cnt_q  <= '0;
            redir_pend_q <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if ((ext_stall || load_use) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;

            if (ext_stall) begin
                redir_pend_q <= redir_pend_q | redirect;
            end else begin
                redir_pend_q <= 1'b0;
                for (int i = DEPTH - 1; i >= 2; i--)
                    sb_q[i] <= sb_q[i-1];
                sb_q[1] <= s1_next;

                fwd_a <= (!bubble && hit_a) ? FWD_W'(fwd_code(32'(k_a))) : FWD_W'(FWD_RF);
                fwd_b <= (!bubble && hit_b) ? FWD_W'(fwd_code(32'(k_b))) : FWD_W'(FWD_RF);

                if (redir_go)
                    flush_cnt_q <= FC_W'(BR_FLUSH - 1);
                else if (flushing)
                    flush_cnt_q <= flush_cnt_q - 1'b1;
            end
        end
    end

endmodule
